// File: rtl/stage_fe_pkg.sv
// Shared widths, the NOP encoding and the response record for the fetch stage.
// The optional FE_PERF_CNT_EN build flag is consumed by stage_fe.
`ifndef STAGE_FE_DEFINES
`define STAGE_FE_DEFINES
`define INST_W 32
`define INST_ADDR_W 16
`define INST_NOP 32'h00000013
`endif

package stage_fe_pkg;

  localparam int unsigned InstW     = `INST_W;
  localparam int unsigned InstAddrW = `INST_ADDR_W;
  localparam logic [InstW-1:0] InstNop = `INST_NOP;

  typedef struct packed {
    logic [InstAddrW-1:0] pc;
    logic [InstW-1:0]     inst;
  } fe_resp_t;

endpackage

// File: rtl/fe_fifo.sv
// Small synchronous FIFO with clear; DEPTH must be a power of two so the
// pointers wrap naturally.
module fe_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o && !pop_i && !clr_i))
    else $error("fe_fifo overflow");

endmodule

// File: rtl/stage_fe.sv
// Instruction fetch stage: pipelined imem requests, response buffering, redirect kill.
// Define FE_PERF_CNT_EN to add the perf_fetched / perf_bubbles counters.
module stage_fe
  import stage_fe_pkg::*;
#(
  parameter logic [InstAddrW-1:0] RESET_PC  = '0,
  parameter int unsigned          MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [InstAddrW-1:0] redirect_pc,
  output logic                 imem_req,
  output logic [InstAddrW-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [InstW-1:0]     imem_rdata,
  output logic [InstW-1:0]     inst,
  output logic [InstAddrW-1:0] pc,
  output logic                 flush
`ifdef FE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_bubbles
`endif
);

  localparam int unsigned CntW = $clog2(MAX_OUTST + 1);
  localparam int unsigned SumW = CntW + 1;

  logic [InstAddrW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]      outst_q, outst_d;
  logic [CntW-1:0]      drop_q, drop_d;
  logic [InstW-1:0]     inst_q, inst_d;
  logic [InstAddrW-1:0] pc_q, pc_d;
  logic                 flush_q, flush_d;

  logic [InstAddrW-1:0] tag_head;
  logic [CntW-1:0]      tag_cnt, resp_cnt;
  logic                 tag_full, tag_empty, resp_full, resp_empty;
  fe_resp_t             resp_wdata, resp_head;

  logic accept, dropping, live_rsp, upd, bypass, resp_push, resp_pop, tag_pop;
  logic [SumW-1:0] credit_used;

  assign credit_used = SumW'(outst_q) + SumW'(resp_cnt);
  assign imem_req    = en && !redirect && (credit_used < SumW'(MAX_OUTST));
  assign imem_addr   = fetch_pc_q;
  assign accept      = imem_req && imem_ready;

  // Words belonging to fetches killed by a redirect are discarded on arrival; their
  // tags were already cleared, so they must not pop the tag FIFO.
  assign dropping = imem_rvalid && (drop_q != '0);
  assign live_rsp = imem_rvalid && !dropping && !redirect;
  assign tag_pop  = imem_rvalid && !dropping;

  assign upd = en && (!stall || redirect);
  // With an empty buffer a fresh word goes straight to the output register, which is
  // what sustains one instruction per cycle under the credit limit.
  assign bypass    = upd && !redirect && resp_empty && live_rsp;
  assign resp_pop  = upd && !redirect && !resp_empty;
  assign resp_push = live_rsp && !bypass;

  assign resp_wdata = '{pc: tag_head, inst: imem_rdata};

  fe_fifo #(
    .W    (InstAddrW),
    .DEPTH(MAX_OUTST)
  ) u_tag_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (redirect),
    .push_i (accept),
    .wdata_i(fetch_pc_q),
    .pop_i  (tag_pop),
    .rdata_o(tag_head),
    .count_o(tag_cnt),
    .full_o (tag_full),
    .empty_o(tag_empty)
  );

  fe_fifo #(
    .W    ($bits(fe_resp_t)),
    .DEPTH(MAX_OUTST)
  ) u_resp_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (redirect),
    .push_i (resp_push),
    .wdata_i(resp_wdata),
    .pop_i  (resp_pop),
    .rdata_o(resp_head),
    .count_o(resp_cnt),
    .full_o (resp_full),
    .empty_o(resp_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CntW'(accept) - CntW'(imem_rvalid);
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      drop_d     = outst_q - CntW'(imem_rvalid);
    end else begin
      if (accept)   fetch_pc_d = fetch_pc_q + InstAddrW'(1);
      if (dropping) drop_d = drop_q - CntW'(1);
    end
  end

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    if (upd) begin
      if (redirect) begin
        inst_d  = InstNop;
        flush_d = 1'b1;
      end else if (!resp_empty) begin
        inst_d  = resp_head.inst;
        pc_d    = resp_head.pc;
        flush_d = 1'b0;
      end else if (bypass) begin
        inst_d  = imem_rdata;
        pc_d    = tag_head;
        flush_d = 1'b0;
      end else begin
        inst_d  = InstNop;
        flush_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      inst_q     <= InstNop;
      pc_q       <= '0;
      flush_q    <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
    end
  end

  assign inst  = inst_q;
  assign pc    = pc_q;
  assign flush = flush_q;

`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else if (en && !stall) begin
      if (flush_q) perf_bubbles_q <= perf_bubbles_q + 32'd1;
      else         perf_fetched_q <= perf_fetched_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

  // Every live tag belongs to an outstanding fetch that will not be dropped.
  assert property (@(posedge clk) disable iff (rst) tag_cnt == outst_q - drop_q)
    else $error("stage_fe tag/outstanding mismatch");
  assert property (@(posedge clk) disable iff (rst) !(accept && tag_full))
    else $error("stage_fe tag overflow");
  assert property (@(posedge clk) disable iff (rst) !(tag_pop && !redirect && tag_empty))
    else $error("stage_fe response without tag");
  assert property (@(posedge clk) disable iff (rst) !(resp_push && resp_full && !resp_pop))
    else $error("stage_fe response overflow");

endmodule

// File: tb/tb_stage_fe.sv
// Directed bench for stage_fe with a behavioural imem (mem[i] = i, latency 1 or 3).
module tb_stage_fe;

  logic        clk = 1'b0;
  logic        rst, en, stall, redirect, imem_ready;
  logic [15:0] redirect_pc, imem_addr, pc;
  logic        imem_req, imem_rvalid, flush;
  logic [31:0] imem_rdata, inst;

  logic        req_w, rvalid_w, flush_w;
  logic [15:0] addr_w, raddr_w, pc_w;
  logic [31:0] inst_w;

`ifdef FE_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_fetched_w, perf_bubbles_w;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 1;
  int out_cnt  = 0;

  logic        v_sh [3];
  logic [15:0] a_sh [3];

  always #5 clk = ~clk;

  stage_fe #(.RESET_PC(16'h0000), .MAX_OUTST(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .pc         (pc),
    .flush      (flush)
`ifdef FE_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  stage_fe #(.RESET_PC(16'hFFFF), .MAX_OUTST(2)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .stall      (1'b0),
    .redirect   (1'b0),
    .redirect_pc(16'h0000),
    .imem_req   (req_w),
    .imem_addr  (addr_w),
    .imem_ready (1'b1),
    .imem_rvalid(rvalid_w),
    .imem_rdata ({16'h0000, raddr_w}),
    .inst       (inst_w),
    .pc         (pc_w),
    .flush      (flush_w)
`ifdef FE_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched_w),
    .perf_bubbles(perf_bubbles_w)
`endif
  );

  assign imem_rvalid = v_sh[0];
  assign imem_rdata  = {16'h0000, a_sh[0]};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        v_sh[i] <= 1'b0;
        a_sh[i] <= '0;
      end
      out_cnt <= 0;
    end else begin
      v_sh[0] <= v_sh[1];
      v_sh[1] <= v_sh[2];
      v_sh[2] <= 1'b0;
      a_sh[0] <= a_sh[1];
      a_sh[1] <= a_sh[2];
      if (imem_req && imem_ready) begin
        v_sh[lat-1] <= 1'b1;
        a_sh[lat-1] <= imem_addr;
      end
      out_cnt <= out_cnt + int'(imem_req && imem_ready) - int'(imem_rvalid);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_w <= 1'b0;
      raddr_w  <= '0;
    end else begin
      rvalid_w <= req_w;
      raddr_w  <= addr_w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst         = 1'b1;
    en          = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b1;
    lat         = l;
    repeat (2) step();
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (flush && cycles < 20) begin
      step();
      cycles++;
    end
    if (flush) check({tag, "_timeout"}, 32'(flush), 32'd0);
  endtask

  initial begin
    int cyc;
    int expct;
    int max_out;
    int n_deliv;

    // Reset state
    rst = 1'b1; en = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = '0; imem_ready = 1'b1; lat = 1;
    repeat (2) step();
    check("rst_flush", 32'(flush), 32'd1);
    check("rst_inst", inst, 32'h00000013);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // Test 1: back-to-back stream; wrap instance checked alongside
    rst = 1'b0;
    en  = 1'b1;
    wait_valid("t1", cyc);
    check("t1_first_lat", cyc, 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("t1_pc", 32'(pc), 32'(i));
      check("t1_inst", inst, 32'(i));
      check("t1_flush", 32'(flush), 32'd0);
      if (i < 2) begin
        check("t6_wrap_pc", 32'(pc_w), (i == 0) ? 32'h0000FFFF : 32'h0);
        check("t6_wrap_inst", inst_w, (i == 0) ? 32'h0000FFFF : 32'h0);
      end
      step();
    end
`ifdef FE_PERF_CNT_EN
    check("t6_perf_fetched", perf_fetched, 32'd8);
    check("t6_perf_bubbles", perf_bubbles, 32'd2);
`endif

    // Test 2: five-cycle stall with pc 8 on the output
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_pc", 32'(pc), 32'd8);
      check("t2_hold_flush", 32'(flush), 32'd0);
    end
    check("t2_req_off", 32'(imem_req), 32'd0);
    stall = 1'b0;
    for (int i = 9; i < 15; i++) begin
      step();
      check("t2_resume_pc", 32'(pc), 32'(i));
      check("t2_resume_flush", 32'(flush), 32'd0);
    end

    // Test 3: redirect with two fetches in flight, 3-cycle imem
    do_reset(3);
    repeat (2) step();
    check("t3_inflight", out_cnt, 32'd2);
    check("t3_req_limit", 32'(imem_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    check("t3_flush", 32'(flush), 32'd1);
    wait_valid("t3", cyc);
    check("t3_pc", 32'(pc), 32'h40);
    check("t3_inst", inst, 32'h40);

    // Test 4: redirect with stall, coinciding with a response
    do_reset(1);
    wait_valid("t4", cyc);
    repeat (3) step();
    check("t4_pre_pc", 32'(pc), 32'd3);
    check("t4_rvalid", 32'(imem_rvalid), 32'd1);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    step();
    check("t4_flush", 32'(flush), 32'd1);
    redirect = 1'b0;
    stall    = 1'b0;
    wait_valid("t4", cyc);
    check("t4_latency", cyc + 1, 32'd3);
    check("t4_pc", 32'(pc), 32'h100);
    check("t4_inst", inst, 32'h100);
    step();
    check("t4_pc_next", 32'(pc), 32'h101);

    // Test 5: random imem_ready, 3-cycle latency
    do_reset(3);
    expct   = 0;
    max_out = 0;
    n_deliv = 0;
    for (int i = 0; i < 300; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      step();
      if (out_cnt > max_out) max_out = out_cnt;
      if (!flush) begin
        check("t5_pc", 32'(pc), 32'(expct));
        check("t5_inst", inst, 32'(expct));
        expct++;
        n_deliv++;
      end
    end
    check("t5_max_outst", 32'(max_out <= 2), 32'd1);
    check("t5_progress", 32'(n_deliv > 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
